// File: rtl/commu_pkg.sv
// Shared definitions for the commu receive-checker slice.
//   rx_state_t    : checker FSM states (IDLE / RUN / DONE)
//   PAT_FIXED_DEF : default byte expected in fixed-pattern mode
//   sat_inc32/16  : saturating increment helpers for the counters
package commu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } rx_state_t;

  localparam logic [7:0] PAT_FIXED_DEF = 8'h55;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/commu_rx_tmo.sv
// Microsecond idle counter for the receive checker.
//   clk_sys  : system clock
//   rst_n    : asynchronous active-low reset
//   pluse_us : one-cycle strobe per microsecond
//   run      : counting enabled (checker in RUN, not being cleared)
//   kick     : byte received this cycle; clears the count and wins over pluse_us
//   tmo      : combinational; high in the cycle whose pluse_us makes the count
//              reach TIMEOUT_US, so the checker reacts on that same edge
module commu_rx_tmo #(
  parameter logic [31:0] TIMEOUT_US = 32'd1000
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic pluse_us,
  input  logic run,
  input  logic kick,
  output logic tmo
);

  logic [31:0] us_cnt;
  logic        hit;

  // 33-bit compare so a count near all-ones cannot wrap past the limit.
  assign hit = run && !kick && pluse_us &&
               (({1'b0, us_cnt} + 33'd1) >= {1'b0, TIMEOUT_US});
  assign tmo = hit;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      us_cnt <= '0;
    end else if (!run || kick || hit) begin
      us_cnt <= '0;
    end else if (pluse_us) begin
      us_cnt <= us_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/commu_rx_chk.sv
// Receive-stream checker: compares incoming bytes against a fixed or
// incrementing pattern, counts bytes and mismatches, and finishes on
// expected count or on an idle timeout.
//   clk_sys, rst_n      : clock, asynchronous active-low reset
//   pluse_us            : 1 us strobe for the idle timeout
//   rx_vld, rx_data     : received byte strobe and data
//   rx_clr              : synchronous restart (wins over rx_vld)
//   tx_pattern          : 0 = fixed PAT_FIXED, 1 = incrementing (latched at run start)
//   tx_total            : expected byte count, 0 = unbounded
//   rx_total, err_cnt   : accepted bytes / mismatches (saturating)
//   rx_error            : sticky mismatch flag
//   first_err_idx       : index of first mismatching byte
//   rx_done, rx_tmo     : run ended by count / by timeout
//   rx_ovf              : byte seen while DONE
//   now_recv            : high while in RUN
module commu_rx_chk
  import commu_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_US = 32'd1000,
  parameter logic [7:0]  PAT_FIXED  = PAT_FIXED_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        pluse_us,
  input  logic        rx_vld,
  input  logic [7:0]  rx_data,
  input  logic        rx_clr,
  input  logic        tx_pattern,
  input  logic [31:0] tx_total,
  output logic [31:0] rx_total,
  output logic        rx_error,
  output logic [15:0] err_cnt,
  output logic [31:0] first_err_idx,
  output logic        rx_done,
  output logic        rx_tmo,
  output logic        rx_ovf,
  output logic        now_recv
);

  rx_state_t   state;
  logic        pat_mode;
  logic [7:0]  exp_byte;
  logic        tmo;

  logic        pat_sel;
  logic        byte_bad;
  logic [31:0] total_nxt;
  logic        count_hit;

  commu_rx_tmo #(
    .TIMEOUT_US (TIMEOUT_US)
  ) u_tmo (
    .clk_sys  (clk_sys),
    .rst_n    (rst_n),
    .pluse_us (pluse_us),
    .run      ((state == ST_RUN) && !rx_clr),
    .kick     (rx_vld),
    .tmo      (tmo)
  );

  // The first byte of a run is checked with the live tx_pattern since the
  // latched copy only becomes valid on the edge that accepts it.
  always_comb begin
    pat_sel   = (state == ST_IDLE) ? tx_pattern : pat_mode;
    byte_bad  = pat_sel ? (rx_data != exp_byte) : (rx_data != PAT_FIXED);
    total_nxt = sat_inc32(rx_total);
    count_hit = (tx_total != '0) && (total_nxt == tx_total);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      pat_mode      <= 1'b0;
      exp_byte      <= '0;
      rx_total      <= '0;
      rx_error      <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      rx_done       <= 1'b0;
      rx_tmo        <= 1'b0;
      rx_ovf        <= 1'b0;
      now_recv      <= 1'b0;
    end else if (rx_clr) begin
      state         <= ST_IDLE;
      pat_mode      <= 1'b0;
      exp_byte      <= '0;
      rx_total      <= '0;
      rx_error      <= 1'b0;
      err_cnt       <= '0;
      first_err_idx <= '0;
      rx_done       <= 1'b0;
      rx_tmo        <= 1'b0;
      rx_ovf        <= 1'b0;
      now_recv      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RUN: begin
          if (rx_vld) begin
            pat_mode <= pat_sel;
            exp_byte <= exp_byte + 8'd1;
            rx_total <= total_nxt;
            if (byte_bad) begin
              rx_error <= 1'b1;
              err_cnt  <= sat_inc16(err_cnt);
              if (!rx_error) first_err_idx <= rx_total;
            end
            if (count_hit) begin
              state    <= ST_DONE;
              rx_done  <= 1'b1;
              now_recv <= 1'b0;
            end else begin
              state    <= ST_RUN;
              now_recv <= 1'b1;
            end
          end else if ((state == ST_RUN) && tmo) begin
            state    <= ST_DONE;
            rx_tmo   <= 1'b1;
            now_recv <= 1'b0;
          end
        end
        ST_DONE: begin
          if (rx_vld) rx_ovf <= 1'b1;
        end
        default: begin
          state    <= ST_IDLE;
          now_recv <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_commu_rx_chk.sv
// Self-checking bench for commu_rx_chk with a behavioural reference model.
module tb_commu_rx_chk;

  localparam logic [7:0]  PAT = 8'h55;
  localparam int unsigned TMO = 5;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        pluse_us;
  logic        rx_vld;
  logic [7:0]  rx_data;
  logic        rx_clr;
  logic        tx_pattern;
  logic [31:0] tx_total;
  logic [31:0] rx_total;
  logic        rx_error;
  logic [15:0] err_cnt;
  logic [31:0] first_err_idx;
  logic        rx_done;
  logic        rx_tmo;
  logic        rx_ovf;
  logic        now_recv;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  logic        m_active, m_fin, m_mode;
  logic [31:0] m_total, m_first;
  logic [15:0] m_errs;
  logic        m_err, m_done, m_tmo, m_ovf;
  int unsigned m_idle;

  commu_rx_chk #(
    .TIMEOUT_US (32'd5),
    .PAT_FIXED  (8'h55)
  ) dut (
    .clk_sys       (clk_sys),
    .rst_n         (rst_n),
    .pluse_us      (pluse_us),
    .rx_vld        (rx_vld),
    .rx_data       (rx_data),
    .rx_clr        (rx_clr),
    .tx_pattern    (tx_pattern),
    .tx_total      (tx_total),
    .rx_total      (rx_total),
    .rx_error      (rx_error),
    .err_cnt       (err_cnt),
    .first_err_idx (first_err_idx),
    .rx_done       (rx_done),
    .rx_tmo        (rx_tmo),
    .rx_ovf        (rx_ovf),
    .now_recv      (now_recv)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic model_clear();
    m_active = 0; m_fin = 0; m_mode = 0;
    m_total = 0; m_first = 0; m_errs = 0;
    m_err = 0; m_done = 0; m_tmo = 0; m_ovf = 0;
    m_idle = 0;
  endtask

  // Byte n of a run is expected to be n mod 256 (incrementing) or PAT.
  task automatic model_step(input logic v, input logic [7:0] d,
                            input logic p, input logic c);
    logic [7:0] want;
    if (c) begin
      model_clear();
    end else if (m_fin) begin
      if (v) m_ovf = 1;
    end else if (v) begin
      if (!m_active) begin
        m_mode   = tx_pattern;
        m_active = 1;
      end
      want = m_mode ? m_total[7:0] : PAT;
      if (d !== want) begin
        if (!m_err) m_first = m_total;
        m_err = 1;
        if (m_errs != 16'hFFFF) m_errs = m_errs + 16'd1;
      end
      if (m_total != 32'hFFFF_FFFF) m_total = m_total + 32'd1;
      m_idle = 0;
      if (tx_total != 0 && m_total == tx_total) begin
        m_done = 1; m_fin = 1; m_active = 0;
      end
    end else if (m_active && p) begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_tmo = 1; m_fin = 1; m_active = 0; m_idle = 0;
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d,
                       input logic p, input logic c);
    rx_vld = v; rx_data = d; pluse_us = p; rx_clr = c;
    @(posedge clk_sys);
    #1;
    model_step(v, d, p, c);
  endtask

  task automatic test_reset();
    rst_n = 0; rx_vld = 0; rx_data = 0; pluse_us = 0; rx_clr = 0;
    tx_pattern = 0; tx_total = 0;
    model_clear();
    #2;
    n_cmp++;
    if ({rx_total, rx_error, err_cnt, first_err_idx, rx_done, rx_tmo, rx_ovf, now_recv} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got total=%0d err=%b ecnt=%0d first=%0d done=%b tmo=%b ovf=%b recv=%b, want all 0",
               rx_total, rx_error, err_cnt, first_err_idx, rx_done, rx_tmo, rx_ovf, now_recv);
    end
    #10 rst_n = 1;
    // pulses while idle must not pre-load the timeout counter
    for (int i = 0; i < 10; i++) drive(0, 8'h00, 1, 0);
    drive(1, PAT, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 1, 0);
    n_cmp++;
    if (rx_tmo !== 1'b0 || now_recv !== 1'b1 || rx_total !== 32'd1) begin
      n_bad++;
      $display("FAIL idle_no_tmo: got tmo=%b recv=%b total=%0d, want 0 1 1", rx_tmo, now_recv, rx_total);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_fixed();
    tx_pattern = 0; tx_total = 4;
    for (int i = 0; i < 4; i++) drive(1, PAT, 0, 0);
    n_cmp++;
    if ({rx_total, rx_done, rx_error, err_cnt, now_recv} !== {32'd4, 1'b1, 1'b0, 16'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL fixed_basic: got total=%0d done=%b err=%b ecnt=%0d recv=%b, want 4 1 0 0 0",
               rx_total, rx_done, rx_error, err_cnt, now_recv);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_incr_wrap();
    logic [7:0] b;
    tx_pattern = 1; tx_total = 300;
    for (int i = 0; i < 300; i++) begin
      b = 8'(i);
      if (i == 1) tx_pattern = 0;   // must be ignored mid-run
      drive(1, b, 0, 0);
    end
    n_cmp++;
    if ({rx_total, rx_done, rx_error, err_cnt} !== {32'd300, 1'b1, 1'b0, 16'd0}) begin
      n_bad++;
      $display("FAIL incr_wrap: got total=%0d done=%b err=%b ecnt=%0d, want 300 1 0 0",
               rx_total, rx_done, rx_error, err_cnt);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_errors();
    logic [7:0] b;
    tx_pattern = 0; tx_total = 10;
    for (int i = 0; i < 10; i++) begin
      b = (i == 3) ? 8'h54 : (i == 7) ? 8'h00 : PAT;
      drive(1, b, 0, 0);
    end
    n_cmp++;
    if ({err_cnt, first_err_idx, rx_error, rx_done, rx_total} !== {16'd2, 32'd3, 1'b1, 1'b1, 32'd10}) begin
      n_bad++;
      $display("FAIL errors: got ecnt=%0d first=%0d err=%b done=%b total=%0d, want 2 3 1 1 10",
               err_cnt, first_err_idx, rx_error, rx_done, rx_total);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_timeout();
    tx_pattern = 0; tx_total = 10;
    drive(1, PAT, 0, 0);
    drive(1, PAT, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 1, 0);
    n_cmp++;
    if (rx_tmo !== 1'b0 || now_recv !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_early: got tmo=%b recv=%b after 4 us, want 0 1", rx_tmo, now_recv);
    end
    drive(0, 8'h00, 1, 0);
    n_cmp++;
    if ({rx_tmo, rx_total, now_recv, rx_done} !== {1'b1, 32'd2, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL tmo_fire: got tmo=%b total=%0d recv=%b done=%b, want 1 2 0 0",
               rx_tmo, rx_total, now_recv, rx_done);
    end
    drive(0, 8'h00, 0, 1);
    // coincident pulse with a byte: byte wins, count restarts from 0
    drive(1, PAT, 0, 0);
    drive(1, PAT, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 8'h00, 1, 0);
    drive(1, PAT, 1, 0);
    for (int i = 0; i < 4; i++) drive(0, 8'h00, 1, 0);
    n_cmp++;
    if (rx_tmo !== 1'b0 || now_recv !== 1'b1 || rx_total !== 32'd3) begin
      n_bad++;
      $display("FAIL tmo_coincident: got tmo=%b recv=%b total=%0d, want 0 1 3", rx_tmo, now_recv, rx_total);
    end
    drive(0, 8'h00, 1, 0);
    n_cmp++;
    if (rx_tmo !== 1'b1 || rx_total !== 32'd3) begin
      n_bad++;
      $display("FAIL tmo_after_kick: got tmo=%b total=%0d, want 1 3", rx_tmo, rx_total);
    end
  endtask

  // continues from the timed-out run left by test_timeout
  task automatic test_overflow_clr();
    drive(1, 8'h12, 1, 0);
    n_cmp++;
    if ({rx_ovf, rx_total, rx_error, err_cnt, rx_tmo} !== {1'b1, 32'd3, 1'b0, 16'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf: got ovf=%b total=%0d err=%b ecnt=%0d tmo=%b, want 1 3 0 0 1",
               rx_ovf, rx_total, rx_error, err_cnt, rx_tmo);
    end
    drive(1, PAT, 0, 1);
    n_cmp++;
    if ({rx_total, rx_error, err_cnt, first_err_idx, rx_done, rx_tmo, rx_ovf, now_recv} !== '0) begin
      n_bad++;
      $display("FAIL clr_with_vld: got total=%0d err=%b ecnt=%0d done=%b tmo=%b ovf=%b recv=%b, want all 0",
               rx_total, rx_error, err_cnt, rx_done, rx_tmo, rx_ovf, now_recv);
    end
  endtask

  task automatic test_async_reset();
    logic [7:0] b;
    tx_pattern = 1; tx_total = 0;
    for (int i = 0; i < 50; i++) begin
      b = (i == 20) ? 8'hEE : 8'(i);
      drive(1, b, 0, 0);
    end
    n_cmp++;
    if (rx_total !== 32'd50 || err_cnt !== 16'd1 || now_recv !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_run: got total=%0d ecnt=%0d recv=%b, want 50 1 1", rx_total, err_cnt, now_recv);
    end
    rx_vld = 0;
    rst_n = 0;
    #1;
    n_cmp++;
    if ({rx_total, rx_error, err_cnt, first_err_idx, rx_done, rx_tmo, rx_ovf, now_recv} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got total=%0d err=%b ecnt=%0d first=%0d recv=%b, want all 0",
               rx_total, rx_error, err_cnt, first_err_idx, now_recv);
    end
    #3 rst_n = 1;
    model_clear();
    drive(1, 8'h00, 0, 0);
    n_cmp++;
    if ({rx_total, rx_error, err_cnt, now_recv} !== {32'd1, 1'b0, 16'd0, 1'b1}) begin
      n_bad++;
      $display("FAIL restart_after_reset: got total=%0d err=%b ecnt=%0d recv=%b, want 1 0 0 1",
               rx_total, rx_error, err_cnt, now_recv);
    end
    drive(0, 8'h00, 0, 1);
  endtask

  task automatic test_random();
    logic [84:0] got, want;
    logic        v, p, c, mode;
    logic [7:0]  d;
    for (int i = 0; i < 2000; i++) begin
      c = ($urandom_range(0, 99) < 3);
      if (c) begin
        tx_pattern = 1'($urandom_range(0, 1));
        tx_total   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 24));
      end
      v = ($urandom_range(0, 99) < 45);
      p = ($urandom_range(0, 99) < 35);
      mode = m_active ? m_mode : tx_pattern;
      if ($urandom_range(0, 99) < 85) d = mode ? m_total[7:0] : PAT;
      else d = 8'($urandom);
      drive(v, d, p, c);
      got  = {rx_total, rx_error, err_cnt, first_err_idx, rx_done, rx_tmo, rx_ovf, now_recv};
      want = {m_total, m_err, m_errs, m_first, m_done, m_tmo, m_ovf, m_active};
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL random_cycle_%0d: got %h, want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_incr_wrap();
    test_errors();
    test_timeout();
    test_overflow_clr();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/commu_rx_chk.md
COMMU_RX_CHK -- requirements
Module: commu_rx_chk

Interface
REQ-001 SHALL have parameter TIMEOUT_US, default 32'd1000, meaning the idle time in microseconds in RUN before the reception is declared timed out.
REQ-002 SHALL have parameter PAT_FIXED, default 8'h55, meaning the expected byte value in fixed-pattern mode.
REQ-003 clk_sys  input  1  system clock; the only clock in the block.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 pluse_us  input  1  one-clk_sys-wide strobe, once per microsecond.
REQ-006 rx_vld  input  1  one-cycle strobe: a received byte is present on rx_data.
REQ-007 rx_data  input  8  received byte, valid only when rx_vld=1.
REQ-008 rx_clr  input  1  synchronous restart of the checker.
REQ-009 tx_pattern  input  1  pattern select: 0 = fixed PAT_FIXED, 1 = incrementing byte.
REQ-010 tx_total  input  32  expected byte count; 0 = unbounded.
REQ-011 rx_total  output  32  count of bytes accepted in this run.
REQ-012 rx_error  output  1  sticky flag: at least one mismatch.
REQ-013 err_cnt  output  16  mismatch count.
REQ-014 first_err_idx  output  32  0-based index of the first mismatching byte.
REQ-015 rx_done  output  1  run finished because the expected count was reached.
REQ-016 rx_tmo  output  1  run finished because of a timeout.
REQ-017 rx_ovf  output  1  sticky flag: a byte arrived while in DONE.
REQ-018 now_recv  output  1  high while state = RUN.

Function
REQ-019 States SHALL be IDLE, RUN and DONE; all outputs SHALL be registered and SHALL update on the clk_sys edge after the qualifying input cycle (latency 1).
REQ-020 IDLE: on rx_vld, the checker SHALL latch tx_pattern, check the byte, and go to RUN; tx_pattern changes later in the run SHALL be ignored.
REQ-021 Expected byte: PAT_FIXED in fixed mode; in incrementing mode SHALL start at 8'h00 and add 1 after every accepted byte, wrapping 8'hFF -> 8'h00.
REQ-022 Each accepted byte (IDLE or RUN) SHALL increment rx_total, saturating at 32'hFFFF_FFFF.
REQ-023 A mismatching byte SHALL: set rx_error; increment err_cnt, saturating at 16'hFFFF; and, on the first mismatch only, load first_err_idx with the pre-increment rx_total.
REQ-024 RUN -> DONE with rx_done=1 SHALL occur on the byte that makes rx_total equal tx_total when tx_total != 0; with tx_total = 0 the run never completes by count.
REQ-025 RUN: a microsecond idle counter SHALL increment on pluse_us and clear on rx_vld; when it reaches TIMEOUT_US the checker SHALL go to DONE with rx_tmo=1.
REQ-026 If rx_vld and pluse_us occur in the same cycle, rx_vld SHALL take precedence and the idle counter SHALL clear.
REQ-027 DONE: rx_vld SHALL NOT change rx_total or any error state and SHALL set rx_ovf; DONE SHALL be left only by rx_clr or reset.
REQ-028 rx_clr SHALL return the checker to IDLE and clear all outputs and counters to their reset values on the next edge, from any state.
REQ-029 If rx_clr and rx_vld occur in the same cycle, rx_clr SHALL win and the byte SHALL be dropped.
REQ-030 No timeout SHALL occur in IDLE or DONE; the idle counter SHALL hold at 0 in those states.

Reset
REQ-031 rst_n low SHALL asynchronously force: state IDLE; rx_total, err_cnt, first_err_idx and the idle counter to 0; rx_error, rx_done, rx_tmo, rx_ovf and now_recv to 0; expected byte to 8'h00.
REQ-032 Reset asserted mid-run SHALL abort the run with no partial flags retained.

Structure
REQ-033 State encodings and the default PAT_FIXED value SHALL live in the shared package commu_pkg.
REQ-034 The idle/timeout counter SHALL be the sub-module commu_rx_tmo (inputs: clk_sys, rst_n, pluse_us, run, kick; output: tmo); all other logic SHALL stay in commu_rx_chk.

Verification
REQ-035 Fixed mode, tx_total=4, four bytes of 0x55 -> rx_total=4, rx_done=1, rx_error=0, err_cnt=0.
REQ-036 Incrementing mode, tx_total=300, bytes 0x00..0xFF followed by 0x00..0x2B -> rx_done=1, rx_error=0 (wrap checked).
REQ-037 Fixed mode, tx_total=10, byte 3 = 0x54 and byte 7 = 0x00 -> err_cnt=2, first_err_idx=3, rx_error=1, rx_done=1.
REQ-038 TIMEOUT_US=5, tx_total=10, 2 bytes then 5 pluse_us -> rx_tmo=1, rx_total=2, now_recv=0; a pluse_us coincident with rx_vld does not count.
REQ-039 After DONE, one rx_vld -> rx_ovf=1 and rx_total unchanged; then rx_clr together with rx_vld -> IDLE, all outputs 0.
REQ-040 rst_n pulsed low mid-run after 50 bytes -> all outputs 0 immediately (asynchronously); the next byte restarts from IDLE.
